// File: rtl/dram_row_ctrl.sv
// dram_row_ctrl: open-row DRAM controller with per-class access latency and periodic refresh
module dram_row_ctrl #(
    parameter int ROW_BITS    = 4,
    parameter int DATA_W      = 32,
    parameter int HIT_LAT     = 1,
    parameter int EMPTY_LAT   = 3,
    parameter int MISS_LAT    = 5,
    parameter int REFRESH_INT = 64,
    parameter int REFRESH_LAT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                input_valid,
    input  logic                we,
    input  logic [ROW_BITS-1:0] row,
    input  logic [DATA_W-1:0]   wdata,
    output logic                ready,
    output logic [DATA_W-1:0]   content,
    output logic                output_valid,
    output logic                row_hit
);
    localparam int WORDS = 1 << ROW_BITS;
    localparam int RC_W  = $clog2(REFRESH_INT);
    localparam int LC_W  = 16;
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, REFRESH = 2'd2;
    logic [DATA_W-1:0]   mem [WORDS];
    logic [1:0]          state;
    logic [LC_W-1:0]     lat_cnt, acc_lat;
    logic [RC_W-1:0]     ref_cnt;
    logic                pending, open_vld, req_we, req_hit, acc_hit;
    logic [ROW_BITS-1:0] open_row, req_row;
    logic [DATA_W-1:0]   req_wdata;
    assign ready   = state == IDLE && !pending;
    assign acc_hit = open_vld && row == open_row;
    assign acc_lat = acc_hit ? LC_W'(HIT_LAT - 1) : !open_vld ? LC_W'(EMPTY_LAT - 1) : LC_W'(MISS_LAT - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= DATA_W'(i);
            state        <= IDLE;
            lat_cnt      <= '0;
            ref_cnt      <= '0;
            pending      <= 1'b0;
            open_vld     <= 1'b0;
            open_row     <= '0;
            req_row      <= '0;
            req_we       <= 1'b0;
            req_hit      <= 1'b0;
            req_wdata    <= '0;
            content      <= '0;
            output_valid <= 1'b0;
            row_hit      <= 1'b0;
        end else begin
            output_valid <= 1'b0;
            // refresh counter saturates at its terminal value until the refresh is taken
            if (state == IDLE && pending) begin
                ref_cnt <= '0;
                pending <= 1'b0;
            end else if (ref_cnt != RC_W'(REFRESH_INT - 1)) begin
                ref_cnt <= ref_cnt + RC_W'(1);
                if (ref_cnt == RC_W'(REFRESH_INT - 2)) pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pending) begin
                        state    <= REFRESH;
                        lat_cnt  <= LC_W'(REFRESH_LAT - 1);
                        open_vld <= 1'b0;
                    end else if (input_valid) begin
                        state     <= ACCESS;
                        lat_cnt   <= acc_lat;
                        req_row   <= row;
                        req_we    <= we;
                        req_wdata <= wdata;
                        req_hit   <= acc_hit;
                        open_row  <= row;
                        open_vld  <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (lat_cnt == '0) begin
                        if (req_we) mem[req_row] <= req_wdata;
                        content      <= req_we ? req_wdata : mem[req_row];
                        row_hit      <= req_hit;
                        output_valid <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - LC_W'(1);
                    end
                end
                REFRESH: begin
                    if (lat_cnt == '0) state <= IDLE;
                    else lat_cnt <= lat_cnt - LC_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_row_ctrl.sv
// tb_dram_row_ctrl: directed checks of latency classes, handshake, refresh and async reset
module tb_dram_row_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, input_valid = 1'b0, we = 1'b0;
    logic [3:0]  row = '0;
    logic [31:0] wdata = '0;
    logic        ready, output_valid, row_hit;
    logic [31:0] content;
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    dram_row_ctrl dut (
        .clk(clk), .rst_n(rst_n), .input_valid(input_valid), .we(we), .row(row),
        .wdata(wdata), .ready(ready), .content(content), .output_valid(output_valid),
        .row_hit(row_hit)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic req(input string tag, input logic w, input logic [3:0] r, input logic [31:0] d,
                       input int exp_lat, input logic [31:0] exp_data, input logic exp_hit);
        int n, lat;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        input_valid = 1'b1; we = w; row = r; wdata = d;
        @(posedge clk);
        #1 input_valid = 1'b0;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            if (output_valid) break;
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, content, exp_data);
        chk({tag, "_hit"}, {31'd0, row_hit}, {31'd0, exp_hit});
        chk({tag, "_rdy"}, {31'd0, ready}, 32'd1);
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, output_valid}, 32'd0);
    endtask
    initial begin
        int pulses, low, n;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_ov", {31'd0, output_valid}, 32'd0);
        chk("rst_content", content, 32'd0);
        chk("rst_hit", {31'd0, row_hit}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        req("rd2_empty", 1'b0, 4'd2, 32'd0, 3, 32'd2, 1'b0);
        req("rd2_hit", 1'b0, 4'd2, 32'd0, 1, 32'd2, 1'b1);
        req("rd9_miss", 1'b0, 4'd9, 32'd0, 5, 32'd9, 1'b0);
        req("wr9_hit", 1'b1, 4'd9, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1'b1);
        req("rd9_back", 1'b0, 4'd9, 32'd0, 1, 32'hDEADBEEF, 1'b1);
        req("rd15_miss", 1'b0, 4'd15, 32'd0, 5, 32'd15, 1'b0);
        // held request: miss (5) then hits (1) back to back, one pulse per acceptance
        input_valid = 1'b1; we = 1'b0; row = 4'd3;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (output_valid) pulses++;
        end
        input_valid = 1'b0;
        chk("hold_pulses", pulses, 32'd4);
        chk("hold_data", content, 32'd3);
        chk("hold_hit", {31'd0, row_hit}, 32'd1);
        @(negedge clk);
        chk("hold_quiet", {31'd0, output_valid}, 32'd0);
        pulses = 0; n = 0;
        while (ready && n < 100) begin
            @(negedge clk);
            if (output_valid) pulses++;
            n++;
        end
        low = 0;
        while (!ready && low < 20) begin
            if (output_valid) pulses++;
            low++;
            @(negedge clk);
        end
        chk("ref_block", low, 32'd5);
        chk("ref_nopulse", pulses, 32'd0);
        req("ref_rd9", 1'b0, 4'd9, 32'd0, 3, 32'hDEADBEEF, 1'b0);
        req("rd4_miss", 1'b0, 4'd4, 32'd0, 5, 32'd4, 1'b0);
        input_valid = 1'b1; we = 1'b1; row = 4'd9; wdata = 32'h12345678;
        @(posedge clk);
        #1 input_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_content", content, 32'd0);
        chk("arst_ov", {31'd0, output_valid}, 32'd0);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (output_valid) pulses++;
        end
        rst_n = 1'b1;
        chk("arst_nopulse", pulses, 32'd0);
        req("arst_rd9", 1'b0, 4'd9, 32'd0, 3, 32'd9, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
